line_mem_responder: RTL and testbench
=====================================

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

Interface
REQ-001 Parameter: size, default 25, data width of one memory line in bits.
REQ-002 Parameter: memsize, default 5, line-address width; depth = 2^memsize lines.
REQ-003 Parameter: LAT, default 2, read latency in cycles (legal range 1..7).
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous, active-low.
REQ-006 Port: read  input  1  read request from the controller.
REQ-007 Port: write  input  1  write request from the controller.
REQ-008 Port: line  input  memsize  line address of the request.
REQ-009 Port: wdata  input  size  write data.
REQ-010 Port: ready  output  1  responder accepts a request this cycle.
REQ-011 Port: rdata  output  size  read data, meaningful only while valid=1.
REQ-012 Port: valid  output  1  one-cycle pulse marking rdata valid.
REQ-013 Port: wack  output  1  one-cycle pulse acknowledging a completed write.
REQ-014 Port: err  output  1  sticky flag: read and write asserted together while ready.

Function
REQ-015 FSM states SHALL be CLEAR, IDLE, RD_WAIT, RD_OUT, WR.
REQ-016 CLEAR: writes zero to line cnt each cycle, cnt from 0 to 2^memsize-1; ready=0; after the last line, go to IDLE.
REQ-017 CLEAR SHALL last exactly 2^memsize cycles (32 at defaults).
REQ-018 IDLE: ready=1; requests are sampled only in IDLE on a rising edge with ready=1.
REQ-019 Requests asserted while ready=0 SHALL be ignored, not queued.
REQ-020 IDLE, read=1, write=0: latch line; go to RD_WAIT; load the latency counter with LAT-1.
REQ-021 RD_WAIT: decrement the counter each cycle; at 0, go to RD_OUT.
REQ-022 LAT=1: RD_WAIT SHALL last one cycle.
REQ-023 RD_OUT: rdata = mem[latched line]; valid=1 for exactly this cycle; next state IDLE.
REQ-024 Read latency from the sampling edge to valid=1 SHALL be LAT+1 cycles.
REQ-025 IDLE, write=1, read=0: latch line and wdata; go to WR.
REQ-026 WR: mem[line] <= wdata at the end of this cycle; wack=1 for this cycle only; next state IDLE.
REQ-027 A read issued the cycle after wack SHALL return the newly written data.
REQ-028 IDLE, read=1 and write=1: err <= 1; no memory access; remain in IDLE.
REQ-029 err SHALL clear only on reset.
REQ-030 rdata SHALL hold its last value while valid=0.
REQ-031 Address arithmetic: cnt is memsize+1 bits so the terminal compare has no wrap aliasing; line is unsigned and covers the full depth, so no address is out of range.
REQ-032 Back-to-back requests: the earliest next sample is the cycle after RD_OUT or WR, since ready returns to 1 in IDLE.

Reset
REQ-033 rst=0 SHALL immediately force state CLEAR, cnt=0, ready=0, valid=0, wack=0, err=0, rdata=0.
REQ-034 Memory contents are not reset asynchronously; they are zeroed by the CLEAR sweep after rst deasserts.
REQ-035 rst asserted mid-read, mid-write, or mid-CLEAR SHALL abort the operation.
REQ-036 An aborted write SHALL leave that line unmodified or zeroed by the subsequent CLEAR sweep; no partial data is permitted.

Verification
REQ-037 Release rst, wait -> ready=0 for exactly 32 cycles, then ready=1; reading any line returns 0.
REQ-038 Write line 5 = 25'h1ABCDE, then read line 5 -> wack one cycle after the write sample; valid exactly 3 cycles after the read sample (LAT=2); rdata=25'h1ABCDE.
REQ-039 Write line 31 = all-ones, write line 0 = 1, read both -> respective values returned; no cross-line corruption.
REQ-040 Assert read=write=1 in IDLE -> err=1 and stays 1; memory unchanged; a later normal read still works.
REQ-041 Hold read=1 continuously for line 7 -> one valid pulse per LAT+2 cycles; no request accepted while ready=0.
REQ-042 Pull rst low during RD_WAIT -> valid never pulses; CLEAR restarts; after 32 cycles every line reads 0.

Source files
------------

// File: rtl/line_mem_responder.sv
// Single-port line memory responder: clears itself after reset, then serves one
// read (fixed latency) or one write at a time, flagging simultaneous requests.
module line_mem_responder #(
    parameter int unsigned size    = 25,
    parameter int unsigned memsize = 5,
    parameter int unsigned LAT     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read,
    input  logic               write,
    input  logic [memsize-1:0] line,
    input  logic [size-1:0]    wdata,
    output logic               ready,
    output logic [size-1:0]    rdata,
    output logic               valid,
    output logic               wack,
    output logic               err
);

    localparam int unsigned Depth = 1 << memsize;

    localparam logic [2:0] CLEAR   = 3'd0;
    localparam logic [2:0] IDLE    = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] RD_OUT  = 3'd3;
    localparam logic [2:0] WR      = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [memsize:0]   cnt_q, cnt_d;
    logic [2:0]         lat_q, lat_d;
    logic [memsize-1:0] line_q, line_d;
    logic [size-1:0]    wdata_q, wdata_d;
    logic [size-1:0]    rdata_q, rdata_d;
    logic               err_q, err_d;

    logic               mem_we;
    logic [memsize-1:0] mem_addr;
    logic [size-1:0]    mem_wdata;
    logic [size-1:0]    mem [Depth];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_d     = lat_q;
        line_d    = line_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        mem_we    = 1'b0;
        mem_addr  = line_q;
        mem_wdata = wdata_q;

        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q[memsize-1:0];
                mem_wdata = '0;
                cnt_d     = cnt_q + (memsize+1)'(1);
                if (cnt_q == (memsize+1)'(Depth - 1)) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (read && write) begin
                    err_d = 1'b1;
                end else if (read) begin
                    line_d  = line;
                    lat_d   = 3'(LAT - 1);
                    state_d = RD_WAIT;
                end else if (write) begin
                    line_d  = line;
                    wdata_d = wdata;
                    state_d = WR;
                end
            end
            RD_WAIT: begin
                if (lat_q == 3'd0) begin
                    // Capture here so rdata is already stable during RD_OUT.
                    rdata_d = mem[line_q];
                    state_d = RD_OUT;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            RD_OUT: begin
                state_d = IDLE;
            end
            WR: begin
                mem_we  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            lat_q   <= '0;
            line_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            line_q  <= line_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage has no reset; the CLEAR sweep zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    assign ready = (state_q == IDLE);
    assign valid = (state_q == RD_OUT);
    assign wack  = (state_q == WR);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench for line_mem_responder at default parameters.
module tb_line_mem_responder;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [4:0]  line;
    logic [24:0] wdata;
    logic        ready;
    logic [24:0] rdata;
    logic        valid;
    logic        wack;
    logic        err;

    int total;
    int bad;

    line_mem_responder #(
        .size   (25),
        .memsize(5),
        .LAT    (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .read (read),
        .write(write),
        .line (line),
        .wdata(wdata),
        .ready(ready),
        .rdata(rdata),
        .valid(valid),
        .wack (wack),
        .err  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Counts ready=0 cycles from the current negedge; optionally pokes a write
    // during the sweep, which must be ignored.
    task automatic wait_clear(input bit poke);
        int n;
        n = 0;
        if (poke) begin
            write = 1'b1;
            line  = 5'd3;
            wdata = 25'h155;
        end
        while (!ready && n < 100) begin
            n++;
            @(negedge clk);
            if (n == 10) write = 1'b0;
        end
        write = 1'b0;
        check("clear_len", 32'(n), 32'd32);
    endtask

    task automatic do_write(input logic [4:0] a, input logic [24:0] d);
        write = 1'b1;
        line  = a;
        wdata = d;
        @(negedge clk);
        write = 1'b0;
        check("wack_pulse", 32'(wack), 32'd1);
        check("wr_notready", 32'(ready), 32'd0);
        @(negedge clk);
        check("wack_drop", 32'(wack), 32'd0);
    endtask

    task automatic do_read(input logic [4:0] a, input logic [24:0] exp);
        int n;
        read = 1'b1;
        line = a;
        @(negedge clk);
        read = 1'b0;
        n = 1;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rd_latency", 32'(n), 32'd3);
        check("rd_data", 32'(rdata), 32'(exp));
        @(negedge clk);
        check("valid_drop", 32'(valid), 32'd0);
        check("rdata_hold", 32'(rdata), 32'(exp));
    endtask

    initial begin
        int pulses;
        int first;
        total = 0;
        bad   = 0;
        read  = 1'b0;
        write = 1'b0;
        line  = '0;
        wdata = '0;
        rst   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b1;
        wait_clear(1'b0);

        do_read(5'd0, 25'h0);
        do_read(5'd31, 25'h0);

        do_write(5'd5, 25'h1ABCDE);
        do_read(5'd5, 25'h1ABCDE);

        do_write(5'd31, 25'h1FFFFFF);
        do_write(5'd0, 25'h1);
        do_read(5'd31, 25'h1FFFFFF);
        do_read(5'd0, 25'h1);
        do_read(5'd5, 25'h1ABCDE);

        // Simultaneous read and write: flag only, no state change.
        read  = 1'b1;
        write = 1'b1;
        line  = 5'd5;
        wdata = 25'h0;
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
        check("err_set", 32'(err), 32'd1);
        check("err_idle", 32'(ready), 32'd1);
        check("err_nowack", 32'(wack), 32'd0);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 32'd1);
        do_read(5'd5, 25'h1ABCDE);
        check("err_still", 32'(err), 32'd1);

        // Continuous read of line 7: one pulse every LAT+2 cycles.
        do_write(5'd7, 25'h0777);
        pulses = 0;
        first  = 0;
        read   = 1'b1;
        line   = 5'd7;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (valid) begin
                pulses++;
                if (first == 0) first = i;
                check("stream_data", 32'(rdata), 32'h777);
            end
        end
        read = 1'b0;
        check("stream_pulses", 32'(pulses), 32'd4);
        check("stream_first", 32'(first), 32'd3);

        // Reset during RD_WAIT aborts the read and restarts CLEAR.
        read = 1'b1;
        line = 5'd5;
        @(negedge clk);
        read = 1'b0;
        rst  = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd0);
        check("abort_err", 32'(err), 32'd0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        rst = 1'b1;
        wait_clear(1'b1);
        check("abort_novalid", 32'(pulses), 32'd0);
        do_read(5'd5, 25'h0);
        do_read(5'd31, 25'h0);
        do_read(5'd0, 25'h0);
        do_read(5'd7, 25'h0);
        do_read(5'd3, 25'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
